// File: rtl/stage_4_sequencer_pkg.sv
// Shared definitions for the stage-4 output-path sequencer: state encoding
// and the sizing helper used for the settle and drain counters.
package stage_4_sequencer_pkg;

  // Eight sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_SETTLE  = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_EMIT    = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } seq_state_e;

  // Width of a counter that must hold values 0..limit. Never narrower
  // than one bit so a zero limit still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stage_4_sequencer.sv
// Frame-aware control sequencer for the stage-4 output path. Holds the carry
// registers disabled while reset garbage settles, tracks the symbols of a
// frame, issues the two-cycle final-bits flush (capture, then emit), and then
// waits for the last-output flag, reporting done, drain timeout or carry error.
module stage_4_sequencer
  import stage_4_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned DRAIN_TIMEOUT = 8,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 s4_clk,
  input  logic                 s4_reset_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic                 in_flag_last,
  input  logic                 in_carry_error,
  output logic                 flag_first,
  output logic                 final_flag_2_3,
  output logic                 final_flag,
  output logic                 carry_en,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 err_timeout,
  output logic [CNT_WIDTH-1:0] sym_count
);

  localparam int unsigned SW = cnt_width(SETTLE_CYCLES);
  localparam int unsigned DW = cnt_width(DRAIN_TIMEOUT);

  // Terminal counts; a zero-length settle or drain window degenerates to one cycle.
  localparam logic [SW-1:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? SW'(SETTLE_CYCLES - 1) : '0;
  localparam logic [DW-1:0] DRAIN_LAST  = (DRAIN_TIMEOUT > 0) ? DW'(DRAIN_TIMEOUT - 1) : '0;
  localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
  localparam logic [DW-1:0] DRAIN_ONE   = DW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  seq_state_e           state_q;
  logic [SW-1:0]        settle_cnt_q;
  logic [DW-1:0]        drain_cnt_q;
  logic                 first_pending_q;
  logic [CNT_WIDTH-1:0] sym_count_q;
  logic [CNT_WIDTH-1:0] sym_count_d;
  logic                 carry_en_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 error_q;
  logic                 err_timeout_q;
  logic                 final_flag_2_3_q;
  logic                 final_flag_q;
  logic                 accept;

  // Symbol acceptance, first-symbol flag and saturating next count.
  always_comb begin
    accept      = (state_q == ST_RUN) && in_valid;
    flag_first  = accept && first_pending_q;
    sym_count_d = sym_count_q;
    if (!(&sym_count_q)) begin
      sym_count_d = sym_count_q + CNT_ONE;
    end
  end

  // Sequencer FSM with registered outputs and inline settle/drain counters.
  always_ff @(posedge s4_clk) begin
    if (!s4_reset_n) begin
      state_q          <= ST_SETTLE;
      settle_cnt_q     <= '0;
      drain_cnt_q      <= '0;
      first_pending_q  <= 1'b0;
      sym_count_q      <= '0;
      carry_en_q       <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
      err_timeout_q    <= 1'b0;
      final_flag_2_3_q <= 1'b0;
      final_flag_q     <= 1'b0;
    end else begin
      // Final-bit flags are single-cycle pulses unless re-asserted below.
      final_flag_2_3_q <= 1'b0;
      final_flag_q     <= 1'b0;

      // A symbol presented in RUN is counted even if a carry error aborts the frame.
      if (accept) begin
        sym_count_q <= sym_count_d;
      end

      case (state_q)
        ST_SETTLE: begin
          if (settle_cnt_q >= SETTLE_LAST) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            carry_en_q   <= 1'b1;
          end else begin
            settle_cnt_q <= settle_cnt_q + SETTLE_ONE;
          end
        end

        ST_IDLE: begin
          if (start) begin
            state_q         <= ST_RUN;
            busy_q          <= 1'b1;
            first_pending_q <= 1'b1;
            sym_count_q     <= '0;
          end
        end

        ST_RUN: begin
          if (in_carry_error) begin
            state_q       <= ST_ERROR;
            busy_q        <= 1'b0;
            error_q       <= 1'b1;
            err_timeout_q <= 1'b0;
          end else if (accept) begin
            first_pending_q <= 1'b0;
            if (in_last) begin
              state_q          <= ST_CAPTURE;
              final_flag_2_3_q <= 1'b1;
            end
          end
        end

        ST_CAPTURE: begin
          if (in_carry_error) begin
            state_q       <= ST_ERROR;
            busy_q        <= 1'b0;
            error_q       <= 1'b1;
            err_timeout_q <= 1'b0;
          end else begin
            state_q      <= ST_EMIT;
            final_flag_q <= 1'b1;
          end
        end

        ST_EMIT: begin
          if (in_carry_error) begin
            state_q       <= ST_ERROR;
            busy_q        <= 1'b0;
            error_q       <= 1'b1;
            err_timeout_q <= 1'b0;
          end else begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= '0;
          end
        end

        ST_DRAIN: begin
          // Carry error outranks the last-output flag arriving in the same cycle.
          if (in_carry_error) begin
            state_q       <= ST_ERROR;
            busy_q        <= 1'b0;
            error_q       <= 1'b1;
            err_timeout_q <= 1'b0;
          end else if (in_flag_last) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (drain_cnt_q >= DRAIN_LAST) begin
            state_q       <= ST_ERROR;
            busy_q        <= 1'b0;
            error_q       <= 1'b1;
            err_timeout_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + DRAIN_ONE;
          end
        end

        ST_DONE, ST_ERROR: begin
          if (start) begin
            state_q         <= ST_RUN;
            busy_q          <= 1'b1;
            first_pending_q <= 1'b1;
            sym_count_q     <= '0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            err_timeout_q   <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_SETTLE;
        end
      endcase
    end
  end

  assign final_flag_2_3 = final_flag_2_3_q;
  assign final_flag     = final_flag_q;
  assign carry_en       = carry_en_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign err_timeout    = err_timeout_q;
  assign sym_count      = sym_count_q;

endmodule

// File: tb/tb_stage_4_sequencer.sv
// Scoreboard bench for stage_4_sequencer: the stimulus side computes the
// expected event timeline of each frame and queues it; a negedge monitor
// pops an entry for every event the DUT presents and compares it.
module tb_stage_4_sequencer;

  localparam int CW       = 4;
  localparam int SAT      = (1 << CW) - 1;
  localparam int SETTLE   = 3;
  localparam int DRAIN_TO = 8;

  localparam int K_FIRST = 0;
  localparam int K_CAP   = 1;
  localparam int K_EMIT  = 2;
  localparam int K_DONE  = 3;
  localparam int K_ERR   = 4;

  localparam int E_FLAG       = 0;
  localparam int E_TIMEOUT    = 1;
  localparam int E_CERR_DRAIN = 2;
  localparam int E_CERR_RUN   = 3;

  typedef struct {
    int kind;
    int cyc;
    int cnt;
    int eto;
  } ev_t;

  ev_t exp_q[$];

  logic          clk = 1'b0;
  logic          s4_reset_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_flag_last = 1'b0;
  logic          in_carry_error = 1'b0;
  logic          flag_first;
  logic          final_flag_2_3;
  logic          final_flag;
  logic          carry_en;
  logic          busy;
  logic          done;
  logic          error;
  logic          err_timeout;
  logic [CW-1:0] sym_count;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  stage_4_sequencer #(
    .SETTLE_CYCLES(SETTLE),
    .DRAIN_TIMEOUT(DRAIN_TO),
    .CNT_WIDTH(CW)
  ) dut (
    .s4_clk(clk),
    .s4_reset_n(s4_reset_n),
    .start(start),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_flag_last(in_flag_last),
    .in_carry_error(in_carry_error),
    .flag_first(flag_first),
    .final_flag_2_3(final_flag_2_3),
    .final_flag(final_flag),
    .carry_en(carry_en),
    .busy(busy),
    .done(done),
    .error(error),
    .err_timeout(err_timeout),
    .sym_count(sym_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  function automatic int sat(input int n);
    return (n > SAT) ? SAT : n;
  endfunction

  task automatic push(input int k, input int c, input int n, input int e);
    ev_t ev;
    ev.kind = k;
    ev.cyc  = c;
    ev.cnt  = n;
    ev.eto  = e;
    exp_q.push_back(ev);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start          = 1'b0;
    in_valid       = 1'b0;
    in_last        = 1'b0;
    in_flag_last   = 1'b0;
    in_carry_error = 1'b0;
  endtask

  // Monitor: every DUT event must match the head of the expectation queue.
  task automatic check_ev(input int k);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d actual=present required=none", k, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", k, e.kind);
      chk("event_cycle", cyc, e.cyc);
      if (k == K_DONE) begin
        chk("done_sym_count", int'(sym_count), e.cnt);
        chk("done_err_timeout", int'(err_timeout), 0);
        chk("done_with_error", int'(error), 0);
      end else if (k == K_ERR) begin
        chk("err_sym_count", int'(sym_count), e.cnt);
        chk("err_timeout", int'(err_timeout), e.eto);
        chk("error_with_done", int'(done), 0);
      end
    end
  endtask

  logic done_prev = 1'b0;
  logic err_prev  = 1'b0;

  always @(negedge clk) begin
    if (flag_first)           check_ev(K_FIRST);
    if (final_flag_2_3)       check_ev(K_CAP);
    if (final_flag)           check_ev(K_EMIT);
    if (done && !done_prev)   check_ev(K_DONE);
    if (error && !err_prev)   check_ev(K_ERR);
    done_prev = done;
    err_prev  = error;
  end

  // Release reset and confirm carry_en stays low for the settle window.
  task automatic release_reset();
    s4_reset_n = 1'b1;
    for (int i = 1; i <= SETTLE; i++) begin
      tick();
      @(negedge clk);
      chk("carry_en_settle", int'(carry_en), (i == SETTLE) ? 1 : 0);
    end
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_error", int'(error), 0);
    chk("idle_sym_count", int'(sym_count), 0);
  endtask

  // One frame from IDLE/DONE/ERROR: n symbols, then one of four endings.
  task automatic run_frame(input int n, input int ending, input int jw,
                           input int vprob, input bit noise);
    int sent;
    int cerr_at;
    bit v;
    sent    = 0;
    cerr_at = (ending == E_CERR_RUN) ? int'($urandom_range(0, n - 1)) : -1;
    idle_inputs();
    start = 1'b1;
    tick();
    idle_inputs();
    @(negedge clk);
    chk("busy_after_start", int'(busy), 1);
    chk("sym_count_cleared", int'(sym_count), 0);
    chk("done_cleared", int'(done), 0);
    chk("error_cleared", int'(error), 0);
    tick();
    while (sent < n) begin
      idle_inputs();
      if (sent == cerr_at) begin
        in_carry_error = 1'b1;
        if (noise) in_last = 1'($urandom_range(0, 1));
        push(K_ERR, cyc + 1, sat(sent), 0);
        tick();
        idle_inputs();
        tick();
        return;
      end
      v = ($urandom_range(0, 99) < vprob);
      in_valid = v;
      if (v) begin
        in_last = (sent == n - 1);
        if (sent == 0) push(K_FIRST, cyc, 0, 0);
        sent++;
      end else if (noise) begin
        in_last = 1'($urandom_range(0, 1));
        start   = 1'($urandom_range(0, 1));
      end
      tick();
    end
    // Flush: capture pulse now, emit pulse next cycle, then drain.
    push(K_CAP, cyc, 0, 0);
    push(K_EMIT, cyc + 1, 0, 0);
    idle_inputs();
    if (noise) begin
      in_valid = 1'($urandom_range(0, 1));
      in_last  = 1'($urandom_range(0, 1));
    end
    tick();
    idle_inputs();
    if (noise) in_valid = 1'($urandom_range(0, 1));
    tick();
    for (int k = 0; k < DRAIN_TO; k++) begin
      idle_inputs();
      if (noise) in_valid = 1'($urandom_range(0, 1));
      if (k == jw && ending == E_FLAG) begin
        in_flag_last = 1'b1;
        push(K_DONE, cyc + 1, sat(n), 0);
        tick();
        break;
      end
      if (k == jw && ending == E_CERR_DRAIN) begin
        in_flag_last   = 1'b1;
        in_carry_error = 1'b1;
        push(K_ERR, cyc + 1, sat(n), 0);
        tick();
        break;
      end
      if (ending == E_TIMEOUT && k == DRAIN_TO - 1) push(K_ERR, cyc + 1, sat(n), 1);
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    s4_reset_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_carry_en", int'(carry_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_err_timeout", int'(err_timeout), 0);
    chk("rst_final_flag_2_3", int'(final_flag_2_3), 0);
    chk("rst_final_flag", int'(final_flag), 0);
    chk("rst_sym_count", int'(sym_count), 0);
    chk("rst_flag_first", int'(flag_first), 0);
    release_reset();
    tick();

    // Directed frames.
    run_frame(5,  E_FLAG,       1, 100, 1'b0);
    run_frame(1,  E_FLAG,       0, 100, 1'b0);
    run_frame(4,  E_TIMEOUT,    0, 100, 1'b0);
    run_frame(3,  E_CERR_DRAIN, 2, 100, 1'b0);
    run_frame(20, E_FLAG,       0, 100, 1'b0);

    // Reset in the middle of a frame: no flush pulses, counters cleared.
    idle_inputs();
    start = 1'b1;
    tick();
    idle_inputs();
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      if (i == 0) push(K_FIRST, cyc, 0, 0);
      tick();
    end
    idle_inputs();
    s4_reset_n = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_sym_count", int'(sym_count), 0);
    chk("midrst_carry_en", int'(carry_en), 0);
    tick();
    release_reset();
    tick();

    // Randomised frames with protocol noise.
    for (int f = 0; f < 40; f++) begin
      run_frame(int'($urandom_range(1, 20)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, DRAIN_TO - 1)), int'($urandom_range(40, 100)), 1'b1);
      if ($urandom_range(0, 1) == 1) tick();
    end

    tick();
    tick();
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_4_sequencer.md
# stage_4_sequencer

Control FSM for the stage-4 output path (final-bits generator, carry propagation, bitstream registers). It replaces the free-running reset/carry-enable control with a frame-aware sequencer. It also generates the first-symbol flag and the two-cycle end-of-stream flush sequence (final-bits capture, then final-bits emission). It then waits for the last-output flag and reports frame completion, timeout or carry error to the top level.

## Interface
Parameters:
- SETTLE_CYCLES, 3, cycles after reset release during which carry registers are not enabled (absorbs reset-propagation garbage)
- DRAIN_TIMEOUT, 8, max cycles in DRAIN waiting for last-output flag
- CNT_WIDTH, 16, symbol counter width

Ports:
- s4_clk  in  1  clock, all logic on rising edge
- s4_reset_n  in  1  synchronous, active-low reset
- start  in  1  begin a frame (pulse)
- in_valid  in  1  arithmetic-encoder output valid this cycle
- in_last  in  1  qualifies in_valid: this is the last symbol of the frame
- in_flag_last  in  1  stage-4 last-output flag
- in_carry_error  in  1  stage-4 confirmed carry error
- flag_first  out  1  first valid symbol of frame (Mealy, combinational)
- final_flag_2_3  out  1  capture final bits (registered pulse)
- final_flag  out  1  emit final bits into carry propagation (registered pulse)
- carry_en  out  1  enable for stage-4 carry/output registers
- busy  out  1  state in RUN..DRAIN
- done  out  1  frame completed (sticky until start/reset)
- error  out  1  timeout or carry error (sticky until start/reset)
- err_timeout  out  1  error cause: drain timeout
- sym_count  out  CNT_WIDTH  valid symbols accepted this frame, saturating

## Operation
- States: SETTLE, IDLE, RUN, CAPTURE, EMIT, DRAIN, DONE, ERROR.
- SETTLE: counter counts to SETTLE_CYCLES-1 → IDLE. carry_en=0 here only; all other states carry_en=1.
- IDLE: start → RUN. in_valid/in_last ignored, not counted.
- RUN: first_pending set on entry. flag_first = (state==RUN) & in_valid & first_pending. first_pending clears on that cycle. Each in_valid increments sym_count, saturating at all-ones. in_valid & in_last → CAPTURE. in_last without in_valid ignored. start ignored.
- CAPTURE: final_flag_2_3=1 for exactly this cycle → EMIT.
- EMIT: final_flag=1 for exactly this cycle → DRAIN. Drain counter cleared.
- DRAIN: in_flag_last=1 → DONE. Otherwise counter increments; reaching DRAIN_TIMEOUT with no flag → ERROR, err_timeout=1.
- in_carry_error=1 in RUN, CAPTURE, EMIT or DRAIN → ERROR (err_timeout=0). It has priority over every other transition in that cycle, including in_flag_last.
- DONE: done=1. ERROR: error=1.
- start in DONE or ERROR → RUN. This clears done, error, err_timeout and sym_count.
- First symbol is also last (in_valid & in_last & first_pending): flag_first=1 and → CAPTURE in the same cycle; sym_count=1.
- in_valid during CAPTURE/EMIT/DRAIN is a protocol violation: ignored, not counted.

## Timing
- Reset (s4_reset_n=0 at edge): state=SETTLE, all outputs 0 (carry_en, done, error, err_timeout, final flags, busy, sym_count=0), counters 0. Applies mid-frame too; no flush is issued.
- carry_en rises SETTLE_CYCLES edges after the first edge with s4_reset_n=1.
- start sampled at edge N in IDLE: busy=1 after edge N.
- Last symbol sampled at edge N: final_flag_2_3=1 in cycle N+1, final_flag=1 in cycle N+2, DRAIN from N+3.
- in_flag_last sampled high at edge M in DRAIN: done=1, busy=0 after M.
- Timeout: DRAIN entered at edge D, no in_flag_last → error after edge D+DRAIN_TIMEOUT.
- All outputs registered except flag_first.

## Structure
- Shared package: state encoding enum (8 states, 3 bits), SETTLE/DRAIN counter width helper ($clog2 of parameter+1).
- Single module. No sub-module needed; counters live inline. It instantiates in place of top_control at the stage-4 level.

## Test plan
- Reset release with SETTLE_CYCLES=3: carry_en=0 for 3 cycles, then 1; state IDLE; all other outputs 0.
- start, 5 valid symbols, last on 5th: flag_first only on 1st; final_flag_2_3 at +1 and final_flag at +2; in_flag_last 2 cycles later → done=1, sym_count=5.
- Single symbol with in_valid & in_last together: flag_first=1 same cycle, CAPTURE next cycle, sym_count=1.
- No in_flag_last after EMIT: error=1 and err_timeout=1 exactly 8 cycles after DRAIN entry. start → RUN with error cleared and sym_count=0.
- in_carry_error and in_flag_last both high in DRAIN: ERROR (err_timeout=0), done stays 0.
- s4_reset_n=0 during RUN after 3 symbols: next cycle SETTLE, sym_count=0, no final flags pulsed. Also: CNT_WIDTH=4 with 20 symbols → sym_count saturates at 15.
